// File: rtl/int_sequencer.sv
// Interrupt/reset entry controller for the hmc-6502: arbitrates RESET > NMI > IRQ > BRK at
// opcode fetch, forces opcode $00 on a taken interrupt and sequences the 7-cycle entry.
module int_sequencer #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_NMI     = 16'hFFFA,
  parameter logic [15:0] VEC_RST     = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ     = 16'hFFFE
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        i_flag,
  input  logic        sync,
  input  logic [7:0]  data_in,
  output logic [7:0]  op_out,
  output logic        busy,
  output logic        stack_wr,
  output logic        b_flag,
  output logic        vec_rd,
  output logic [15:0] vec_addr,
  output logic        set_i,
  output logic [1:0]  int_ack,
  output logic [1:0]  o_dbg_state
);

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_ENTRY = 2'd2;

  localparam logic [1:0] SRC_IRQ = 2'b01;
  localparam logic [1:0] SRC_NMI = 2'b10;
  localparam logic [1:0] SRC_BRK = 2'b11;

  logic [1:0]             r_state;
  logic [2:0]             r_cnt;
  logic                   r_nmi_pend;
  logic [SYNC_STAGES-1:0] r_nmi_sync;
  logic [SYNC_STAGES-1:0] r_irq_sync;
  logic [15:0]            r_vec;
  logic [1:0]             r_src;
  logic                   r_brk;

  logic w_nmi_fall;
  logic w_irq_req;
  logic w_idle_sync;
  logic w_take_nmi;
  logic w_take_irq;
  logic w_take_brk;
  logic w_take;
  logic w_hijack;

  // Index 0 is the newest sample; the edge is seen between the two oldest stages.
  assign w_nmi_fall  = r_nmi_sync[SYNC_STAGES-1] & ~r_nmi_sync[SYNC_STAGES-2];
  assign w_irq_req   = ~r_irq_sync[SYNC_STAGES-1] & ~i_flag;
  assign w_idle_sync = (r_state == ST_IDLE) && sync;
  assign w_take_nmi  = w_idle_sync & r_nmi_pend;
  assign w_take_irq  = w_idle_sync & ~r_nmi_pend & w_irq_req;
  assign w_take_brk  = w_idle_sync & ~r_nmi_pend & ~w_irq_req & (data_in == 8'h00);
  assign w_take      = w_take_nmi | w_take_irq | w_take_brk;
  assign w_hijack    = (r_state == ST_ENTRY) && (r_cnt == 3'd4) && (r_src != SRC_NMI) && r_nmi_pend;

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RST;
      r_cnt      <= 3'd0;
      r_nmi_pend <= 1'b0;
      r_nmi_sync <= '1;
      r_irq_sync <= '1;
      r_vec      <= VEC_RST;
      r_src      <= 2'b00;
      r_brk      <= 1'b0;
    end else begin
      r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], nmi_n};
      r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], irq_n};
      // Edges are ignored during the reset sequence so a pin held low through reset
      // cannot produce a fresh NMI once the synchroniser refills; set beats clear.
      if (w_nmi_fall && (r_state != ST_RST)) begin
        r_nmi_pend <= 1'b1;
      end else if (w_take_nmi || w_hijack) begin
        r_nmi_pend <= 1'b0;
      end
      case (r_state)
        ST_RST: begin
          if (r_cnt == 3'd6) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        ST_IDLE: begin
          if (w_take) begin
            r_state <= ST_ENTRY;
            r_cnt   <= 3'd1;
            r_brk   <= w_take_brk;
            r_src   <= w_take_nmi ? SRC_NMI : (w_take_irq ? SRC_IRQ : SRC_BRK);
            r_vec   <= w_take_nmi ? VEC_NMI : VEC_IRQ;
          end
        end
        ST_ENTRY: begin
          if (w_hijack) begin
            r_vec <= VEC_NMI;
            r_src <= SRC_NMI;
          end
          if (r_cnt == 3'd6) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
          r_state <= ST_RST;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    op_out      = w_take ? 8'h00 : data_in;
    busy        = (r_state != ST_IDLE);
    stack_wr    = (r_state == ST_ENTRY) && (r_cnt >= 3'd2) && (r_cnt <= 3'd4);
    b_flag      = (r_state == ST_ENTRY) && r_brk;
    vec_rd      = busy && ((r_cnt == 3'd5) || (r_cnt == 3'd6));
    vec_addr    = (busy && (r_cnt == 3'd6)) ? (r_vec + 16'd1) : r_vec;
    set_i       = busy && (r_cnt == 3'd6);
    int_ack     = ((r_state == ST_ENTRY) && (r_cnt == 3'd6)) ? r_src : 2'b00;
    o_dbg_state = r_state;
  end

endmodule
